fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// A pc register addresses an asynchronous ROM; each returned word is pushed,
// together with its address, into a small show-ahead buffer drained by decode.
// Redirects flush the buffer and restart fetch at a new target.
//
// Build option: define FETCH_ALIGN_CHECK_EN to treat a misaligned redirect
// target as a sticky fault (fetch stops until reset). Without it the low two
// bits of the redirect target are simply cleared and the unit never faults.
//
// Handshake toward decode: a head entry transfers on a rising edge where
// instr_valid and instr_ready are both high; while instr_valid is high and
// instr_ready is low, instr_data/instr_pc hold their value; instr_valid never
// depends on instr_ready.

module fetch_unit #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_data,
    output logic [WIDTH-1:0] instr_pc,
    output logic             fetch_fault,
    output logic [0:0]       fsm_state
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [0:0]  ST_RUN     = 1'b0;
    localparam logic [0:0]  ST_FAULT   = 1'b1;
    localparam logic [PW:0] COUNT_FULL = (PW+1)'(DEPTH);

    logic [0:0]       state;
    logic [WIDTH-1:0] pc;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic             push;
    logic             pop;
    logic             misaligned;
    logic [WIDTH-1:0] target;

    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem   [DEPTH];

    // Redirect target decode: either flag a misaligned target or round it down.
`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign target     = redirect_pc;
`else
    assign misaligned = 1'b0;
    assign target     = redirect_pc & ~WIDTH'(3);
`endif

    // Handshake and push/pop qualification; a redirect suppresses both.
    // A full buffer never pushes, even if the head is popped in the same cycle.
    always_comb begin
        instr_valid = 1'b0;
        pop         = 1'b0;
        push        = 1'b0;
        instr_valid = (count != '0) && !redirect_valid;
        pop         = instr_valid && instr_ready;
        push        = (state == ST_RUN) && (count != COUNT_FULL) && !redirect_valid;
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;

    // Run/fault state: a misaligned redirect while running stops fetch for good.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_RUN;
            fault_q <= 1'b0;
        end else if (misaligned && (state == ST_RUN)) begin
            state   <= ST_FAULT;
            fault_q <= 1'b1;
        end
    end

    assign fetch_fault = fault_q;
`else
    // Run/fault state: without alignment checking the unit always runs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
        end
    end

    assign fetch_fault = 1'b0;
`endif

    // Program counter: reset value, redirect target, or sequential advance.
    // Once faulted, redirects flush but leave pc where it stopped.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            if ((state == ST_RUN) && !misaligned) begin
                pc <= target;
            end
        end else if (push) begin
            pc <= pc + WIDTH'(4);
        end
    end

    // Buffer bookkeeping: pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage: contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[tail] <= rom_rdata;
            pc_mem[tail]   <= pc;
        end
    end

    assign rom_address = pc;
    assign instr_data  = data_mem[head];
    assign instr_pc    = pc_mem[head];
    assign fsm_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, random run against a queue model,
// and a pc wrap-around sequence on a second instance.

module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] rom_address;
    logic [31:0] rom_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_fault;
    logic [0:0]  fsm_state;

    logic        w_reset;
    logic [31:0] w_rom_address;
    logic [31:0] w_rom_rdata;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;
    logic        w_instr_valid;
    logic        w_instr_ready;
    logic [31:0] w_instr_data;
    logic [31:0] w_instr_pc;
    logic        w_fetch_fault;
    logic [0:0]  w_fsm_state;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- ROM model: word i at byte address 4*i ----------------
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_rdata   = rom_word(rom_address);
    assign w_rom_rdata = rom_word(w_rom_address);

    fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .DEPTH(4)) u_dut (
        .clock          (clock),
        .reset          (reset),
        .rom_address    (rom_address),
        .rom_rdata      (rom_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault),
        .fsm_state      (fsm_state)
    );

    fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) u_wrap (
        .clock          (clock),
        .reset          (w_reset),
        .rom_address    (w_rom_address),
        .rom_rdata      (w_rom_rdata),
        .redirect_valid (w_redirect_valid),
        .redirect_pc    (w_redirect_pc),
        .instr_valid    (w_instr_valid),
        .instr_ready    (w_instr_ready),
        .instr_data     (w_instr_data),
        .instr_pc       (w_instr_pc),
        .fetch_fault    (w_fetch_fault),
        .fsm_state      (w_fsm_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        rdv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_rom;
        logic        e_fault;
    } vec_t;

    vec_t tv[$];

    task automatic add_vec(input logic rst, input logic rdv, input logic [31:0] rpc,
                           input logic rdy, input logic e_valid, input logic [31:0] e_pc,
                           input logic [31:0] e_rom, input logic e_fault);
        vec_t v;
        v.rst = rst; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_rom = e_rom; v.e_fault = e_fault;
        tv.push_back(v);
    endtask

    task automatic fill_table();
        // reset release with decode always ready
        add_vec(1, 0, 0, 1, 0, 32'h0,  32'h0,  0);
        add_vec(0, 0, 0, 1, 0, 32'h0,  32'h0,  0);
        add_vec(0, 0, 0, 1, 1, 32'h0,  32'h4,  0);
        add_vec(0, 0, 0, 1, 1, 32'h4,  32'h8,  0);
        add_vec(0, 0, 0, 1, 1, 32'h8,  32'hC,  0);
        // mid-run reset, then decode stalled: buffer saturates at four entries
        add_vec(1, 0, 0, 0, 1, 32'hC,  32'h10, 0);
        add_vec(0, 0, 0, 0, 0, 32'h0,  32'h0,  0);
        add_vec(0, 0, 0, 0, 1, 32'h0,  32'h4,  0);
        add_vec(0, 0, 0, 0, 1, 32'h0,  32'h8,  0);
        add_vec(0, 0, 0, 0, 1, 32'h0,  32'hC,  0);
        for (int i = 0; i < 4; i++) add_vec(0, 0, 0, 0, 1, 32'h0, 32'h10, 0);
        // release: the four stalled entries in order, then 0x10
        add_vec(0, 0, 0, 1, 1, 32'h0,  32'h10, 0);
        add_vec(0, 0, 0, 1, 1, 32'h4,  32'h10, 0);
        add_vec(0, 0, 0, 1, 1, 32'h8,  32'h14, 0);
        add_vec(0, 0, 0, 1, 1, 32'hC,  32'h18, 0);
        add_vec(0, 0, 0, 1, 1, 32'h10, 32'h1C, 0);
        // redirect with three entries buffered: nothing stale escapes
        add_vec(0, 1, 32'h200, 1, 0, 32'h0,   32'h20,  0);
        add_vec(0, 0, 0,       1, 0, 32'h0,   32'h200, 0);
        add_vec(0, 0, 0,       1, 1, 32'h200, 32'h204, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        // misaligned redirect: fault, pc frozen, no further fetch
        add_vec(0, 1, 32'h202, 1, 0, 32'h0, 32'h208, 0);
        add_vec(0, 0, 0,       1, 0, 32'h0, 32'h208, 1);
        add_vec(0, 0, 0,       1, 0, 32'h0, 32'h208, 1);
        add_vec(0, 1, 32'h300, 1, 0, 32'h0, 32'h208, 1);
        add_vec(0, 0, 0,       1, 0, 32'h0, 32'h208, 1);
`else
        // misaligned redirect target rounds down to 0x200
        add_vec(0, 1, 32'h202, 1, 0, 32'h0,   32'h208, 0);
        add_vec(0, 0, 0,       1, 0, 32'h0,   32'h200, 0);
        add_vec(0, 0, 0,       1, 1, 32'h200, 32'h204, 0);
`endif
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    logic        m_fault;
    bit          m_known;

    // One clock of the unit's rules applied to the model.
    task automatic model_step(input logic rst, input logic rdv, input logic [31:0] rpc,
                              input logic rdy);
        bit exp_valid;
        bit can_push;
        entry_t e;
        exp_valid = (mq.size() != 0) && !rdv;
        if (rst) begin
            mq.delete();
            m_pc    = 32'h0;
            m_fault = 1'b0;
            m_known = 1'b1;
        end else if (rdv) begin
            mq.delete();
            if (!m_fault) begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (rpc % 4 != 0) m_fault = 1'b1;
                else              m_pc    = rpc;
`else
                m_pc = rpc - (rpc % 4);
`endif
            end
        end else begin
            can_push = !m_fault && (mq.size() < 4);
            if (exp_valid && rdy) void'(mq.pop_front());
            if (can_push) begin
                e.pc   = m_pc;
                e.data = rom_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset            = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        instr_ready      = 1'b1;
        w_reset          = 1'b1;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'h0;
        w_instr_ready    = 1'b1;
        m_known          = 1'b0;
        m_pc             = 32'h0;
        m_fault          = 1'b0;

        repeat (2) @(posedge clock);
        #1;

        // table-driven directed vectors
        fill_table();
        foreach (tv[i]) begin
            reset          = tv[i].rst;
            redirect_valid = tv[i].rdv;
            redirect_pc    = tv[i].rpc;
            instr_ready    = tv[i].rdy;
            @(negedge clock);
            check($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, tv[i].e_valid});
            check($sformatf("vec%0d rom_address", i), rom_address, tv[i].e_rom);
            check($sformatf("vec%0d fetch_fault", i), {31'b0, fetch_fault}, {31'b0, tv[i].e_fault});
            if (tv[i].e_valid) begin
                check($sformatf("vec%0d instr_pc", i), instr_pc, tv[i].e_pc);
                check($sformatf("vec%0d instr_data", i), instr_data, rom_word(tv[i].e_pc));
            end
            @(posedge clock);
            #1;
        end

        // randomized run against the queue model
        for (int i = 0; i < 3000; i++) begin
            reset          = (i == 0) || ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            instr_ready    = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            if (m_known) begin
                check("rnd instr_valid", {31'b0, instr_valid},
                      {31'b0, (mq.size() != 0) && !redirect_valid});
                check("rnd rom_address", rom_address, m_pc);
                check("rnd fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
                if ((mq.size() != 0) && !redirect_valid) begin
                    check("rnd instr_pc", instr_pc, mq[0].pc);
                    check("rnd instr_data", instr_data, mq[0].data);
                end
            end
            model_step(reset, redirect_valid, redirect_pc, instr_ready);
            @(posedge clock);
            #1;
        end
        reset          = 1'b0;
        redirect_valid = 1'b0;

        // pc wrap from 0xFFFF_FFFC to 0x0
        w_reset = 1'b0;
        @(negedge clock);
        check("wrap first cycle valid", {31'b0, w_instr_valid}, 32'h0);
        check("wrap first rom_address", w_rom_address, 32'hFFFF_FFFC);
        @(posedge clock); #1;
        @(negedge clock);
        check("wrap head valid", {31'b0, w_instr_valid}, 32'h1);
        check("wrap head pc", w_instr_pc, 32'hFFFF_FFFC);
        check("wrap head data", w_instr_data, 32'h4FFF_FFFF);
        check("wrap rom_address", w_rom_address, 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        check("wrap next valid", {31'b0, w_instr_valid}, 32'h1);
        check("wrap next pc", w_instr_pc, 32'h0);
        check("wrap next data", w_instr_data, 32'h1000_0000);
        check("wrap next rom_address", w_rom_address, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
